text_write_ctrl: RTL and testbench
==================================

# text_write_ctrl

Write sequencer for the 4×32 character RAM that feeds the VGA text renderer. It takes received UART bytes and interprets printable ASCII and a small control-character set, maintaining the cursor and issuing single-cycle writes on the RAM write port. It also runs a full-screen clear sweep. It replaces the ad-hoc cursor logic in the top level and exports the cursor position for the seven-segment debug display.

## Interface
- COLS, 32, characters per row; power of two; column address width is log2(COLS).
- ROWS, 4, rows; power of two; row address width is log2(ROWS).
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle.
- ready  out  1  high when a byte is accepted this cycle (state IDLE).
- overrun  out  1  one-cycle pulse when rx_valid arrives while ready is low.
- we  out  1  RAM write enable, one cycle per cell.
- wr_row  out  log2(ROWS)  RAM write row.
- wr_col  out  log2(COLS)  RAM write column.
- wr_data  out  8  RAM write data.
- cur_row  out  log2(ROWS)  current cursor row.
- cur_col  out  log2(COLS)  current cursor column.
- busy  out  1  high during a clear sweep.

## Operation
- States are IDLE, PUT and CLEAR.
- **IDLE:** ready=1. On rx_valid, decode rx_data:
  - 0x20–0x7E (printable): latch the byte and the current cursor into the write registers, advance the cursor, go to PUT.
  - 0x0D (CR): set cur_col=0. Stay in IDLE; no write.
  - 0x0A (LF): set cur_row=(cur_row+1) mod ROWS; cur_col is unchanged; no write.
  - 0x08 or 0x7F (BS/DEL): retreat the cursor, then write 0x20 at the new position (PUT). At (0,0) this is a full no-op: no write, no move.
  - 0x0C (FF): enter CLEAR (CLEAR_EN only).
  - Any other byte, including bit7=1: dropped silently.
- **Advance:** increment cur_col. At COLS-1, set cur_col=0 and cur_row=(cur_row+1) mod ROWS. From (ROWS-1, COLS-1) the cursor wraps to (0,0).
- **Retreat:** decrement cur_col. At col 0 with row>0, go to (row-1, COLS-1).
- **PUT:** we=1 for exactly one cycle with the latched row, col and data; return to IDLE.
- **CLEAR:**
  - busy=1, ready=0.
  - Writes 0x20 to every cell in row-major order, (0,0) through (ROWS-1, COLS-1), one cell per cycle: ROWS×COLS consecutive we cycles.
  - After the last cell: cursor is (0,0), state is IDLE.
- **overrun:** rx_valid while ready=0 pulses overrun for one cycle and discards the byte. The design never queues input.
- **Reset:**
  - All outputs go to 0: we, busy, overrun, cursor, wr_* all 0.
  - ready=1 in the first cycle after reset deasserts.
  - Reset during CLEAR aborts the sweep. The RAM stays partially cleared; this is acceptable.

## Timing
- **Printable byte, rx_valid in cycle N:** we=1 in cycle N+1 at the pre-advance cursor. cur_row/cur_col show the advanced position from N+1. ready=0 in N+1 and returns to 1 in N+2.
- **Back-to-back printable bytes:** maximum acceptance rate is one byte per 2 cycles. A UART byte takes about 10k cycles, so overrun indicates a protocol fault only.
- **CR/LF:** the cursor updates in N+1; ready stays 1.
- **FF in cycle N:** busy rises in N+1, and the first write is (0,0) in N+1. The last write is in N+ROWS×COLS. busy falls and ready rises in N+ROWS×COLS+1.
- All outputs are registered; there are no combinational input-to-output paths except ready, which is a state decode.

## Configuration
- Macro: TEXT_WRITE_CTRL_CLEAR_EN.
- Defined: FF (0x0C) triggers the CLEAR sweep; the busy output is driven as specified.
- Undefined:
  - The CLEAR state and the sweep counter are not built.
  - 0x0C is dropped like any other unsupported control byte.
  - busy is tied to 0.

## Structure
- Package text_ctrl_pkg holds:
  - Character constants: CH_CR, CH_LF, CH_BS, CH_DEL, CH_FF, CH_SPACE, PRINT_LO, PRINT_HI.
  - The state encoding (IDLE, PUT, CLEAR).
  - Default COLS/ROWS values.
- One sub-module, text_cursor, holds the cursor registers:
  - Operation inputs advance, retreat, cr, lf, home; one per cycle, priority home > others.
  - Outputs are the cursor position and an at_origin flag.
- The CLEAR sweep reuses text_cursor by issuing home and then advance each cycle, so no separate address counter is needed.

## Test plan
- Reset, then send "A" (0x41) → one we cycle at (0,0) with data 0x41; cursor moves to (0,1); ready is low for exactly one cycle.
- Send 32 printable bytes from (3,0) → the last write is at (3,31); cursor wraps to (0,0); no write is at row 4.
- From (1,5), send CR then LF → cursor (1,0) then (2,0), with zero we cycles. Then send BS → write 0x20 at (1,31) and cursor (1,31). BS at (0,0) → no write, cursor stays.
- Fill the screen, then send FF with CLEAR_EN defined → 128 consecutive we cycles with data 0x20 at addresses (0,0)…(3,31); busy is high for 128 cycles; cursor ends at (0,0). Without CLEAR_EN, FF produces no write and no busy.
- Assert rx_valid with 0x42 in the cycle after an accepted byte (PUT) → overrun pulses once; 0x42 is never written.
- Assert reset in the 40th cycle of a clear sweep → busy=0 and cursor (0,0) in the next cycle; we stays low; the following byte writes to (0,0).

Source files
------------

// File: rtl/text_write_ctrl_pkg.sv
// Shared constants and state encoding for the VGA text write sequencer.
package text_ctrl_pkg;

    localparam int unsigned DEF_COLS = 32;
    localparam int unsigned DEF_ROWS = 4;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_DEL   = 8'h7F;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUT   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_write_ctrl_if.sv
// Byte input and character-RAM write bus of the text write sequencer.
interface text_write_ctrl_if #(
    parameter int unsigned COLS = text_ctrl_pkg::DEF_COLS,
    parameter int unsigned ROWS = text_ctrl_pkg::DEF_ROWS
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    ready;
    logic                    overrun;
    logic                    we;
    logic [$clog2(ROWS)-1:0] wr_row;
    logic [$clog2(COLS)-1:0] wr_col;
    logic [7:0]              wr_data;
    logic [$clog2(ROWS)-1:0] cur_row;
    logic [$clog2(COLS)-1:0] cur_col;
    logic                    busy;

    modport master (
        output rx_data, rx_valid,
        input  ready, overrun, we, wr_row, wr_col, wr_data, cur_row, cur_col, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output ready, overrun, we, wr_row, wr_col, wr_data, cur_row, cur_col, busy
    );
endinterface

// File: rtl/text_write_ctrl_cursor.sv
// Cursor registers; nxt_*_c exposes the position after this cycle's operation.
module text_cursor
    import text_ctrl_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    advance,
    input  logic                    retreat,
    input  logic                    cr,
    input  logic                    lf,
    input  logic                    home,
    output logic [$clog2(ROWS)-1:0] row,
    output logic [$clog2(COLS)-1:0] col,
    output logic                    at_origin,
    output logic [$clog2(ROWS)-1:0] nxt_row_c,
    output logic [$clog2(COLS)-1:0] nxt_col_c
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    // Home wins; retreat from the origin is a no-op.
    always_comb begin
        nxt_row_c = row;
        nxt_col_c = col;
        if (home) begin
            nxt_row_c = '0;
            nxt_col_c = '0;
        end else if (advance) begin
            if (col == CW'(COLS - 1)) begin
                nxt_col_c = '0;
                nxt_row_c = row + RW'(1);
            end else begin
                nxt_col_c = col + CW'(1);
            end
        end else if (retreat) begin
            if (col != '0) begin
                nxt_col_c = col - CW'(1);
            end else if (row != '0) begin
                nxt_row_c = row - RW'(1);
                nxt_col_c = CW'(COLS - 1);
            end
        end else if (cr) begin
            nxt_col_c = '0;
        end else if (lf) begin
            nxt_row_c = row + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            at_origin <= 1'b1;
        end else begin
            row       <= nxt_row_c;
            col       <= nxt_col_c;
            at_origin <= (nxt_row_c == '0) && (nxt_col_c == '0);
        end
    end

endmodule

// File: rtl/text_write_ctrl.sv
// UART-byte to character-RAM write sequencer with cursor tracking.
// TEXT_WRITE_CTRL_CLEAR_EN builds the form-feed full-screen clear sweep.
module text_write_ctrl
    import text_ctrl_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input logic              clk,
    input logic              reset,
    text_write_ctrl_if.slave bus
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    state_t          state;
    state_t          state_n;
    logic            op_adv, op_ret, op_cr, op_lf, op_home;
    logic            we_n, overrun_n;
    logic [RW-1:0]   wr_row_n;
    logic [CW-1:0]   wr_col_n;
    logic [7:0]      wr_data_n;
    logic [RW-1:0]   cur_row, nxt_row;
    logic [CW-1:0]   cur_col, nxt_col;
    logic            at_origin;
    logic            is_erase;
`ifdef TEXT_WRITE_CTRL_CLEAR_EN
    logic            busy_n;
    logic            sweep_last;
    // Cursor about to wrap to the origin marks the final sweep cell.
    assign sweep_last = (nxt_row == '0) && (nxt_col == '0);
`endif

    text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .advance   (op_adv),
        .retreat   (op_ret),
        .cr        (op_cr),
        .lf        (op_lf),
        .home      (op_home),
        .row       (cur_row),
        .col       (cur_col),
        .at_origin (at_origin),
        .nxt_row_c (nxt_row),
        .nxt_col_c (nxt_col)
    );

    assign is_erase    = (bus.rx_data == CH_BS) || (bus.rx_data == CH_DEL);
    assign bus.ready   = (state == IDLE);
    assign bus.cur_row = cur_row;
    assign bus.cur_col = cur_col;
`ifndef TEXT_WRITE_CTRL_CLEAR_EN
    assign bus.busy    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bus.we      <= 1'b0;
            bus.overrun <= 1'b0;
            bus.wr_row  <= '0;
            bus.wr_col  <= '0;
            bus.wr_data <= '0;
`ifdef TEXT_WRITE_CTRL_CLEAR_EN
            bus.busy    <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            bus.we      <= we_n;
            bus.overrun <= overrun_n;
            bus.wr_row  <= wr_row_n;
            bus.wr_col  <= wr_col_n;
            bus.wr_data <= wr_data_n;
`ifdef TEXT_WRITE_CTRL_CLEAR_EN
            bus.busy    <= busy_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (is_printable(bus.rx_data)) state_n = PUT;
                    else if (is_erase && !at_origin) state_n = PUT;
`ifdef TEXT_WRITE_CTRL_CLEAR_EN
                    else if (bus.rx_data == CH_FF) state_n = CLEAR;
`endif
                end
            end
            PUT: state_n = IDLE;
`ifdef TEXT_WRITE_CTRL_CLEAR_EN
            CLEAR: if (sweep_last) state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    // Write address for erase/clear comes from the cursor's post-operation position.
    always_comb begin
        op_adv    = 1'b0;
        op_ret    = 1'b0;
        op_cr     = 1'b0;
        op_lf     = 1'b0;
        op_home   = 1'b0;
        we_n      = 1'b0;
        overrun_n = bus.rx_valid && (state != IDLE);
        wr_row_n  = bus.wr_row;
        wr_col_n  = bus.wr_col;
        wr_data_n = bus.wr_data;
`ifdef TEXT_WRITE_CTRL_CLEAR_EN
        busy_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (is_printable(bus.rx_data)) begin
                        op_adv    = 1'b1;
                        we_n      = 1'b1;
                        wr_row_n  = cur_row;
                        wr_col_n  = cur_col;
                        wr_data_n = bus.rx_data;
                    end else if (bus.rx_data == CH_CR) begin
                        op_cr = 1'b1;
                    end else if (bus.rx_data == CH_LF) begin
                        op_lf = 1'b1;
                    end else if (is_erase) begin
                        if (!at_origin) begin
                            op_ret    = 1'b1;
                            we_n      = 1'b1;
                            wr_row_n  = nxt_row;
                            wr_col_n  = nxt_col;
                            wr_data_n = CH_SPACE;
                        end
`ifdef TEXT_WRITE_CTRL_CLEAR_EN
                    end else if (bus.rx_data == CH_FF) begin
                        op_home   = 1'b1;
                        we_n      = 1'b1;
                        busy_n    = 1'b1;
                        wr_row_n  = nxt_row;
                        wr_col_n  = nxt_col;
                        wr_data_n = CH_SPACE;
`endif
                    end
                end
            end
`ifdef TEXT_WRITE_CTRL_CLEAR_EN
            CLEAR: begin
                op_adv    = 1'b1;
                we_n      = !sweep_last;
                busy_n    = !sweep_last;
                wr_row_n  = nxt_row;
                wr_col_n  = nxt_col;
                wr_data_n = CH_SPACE;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed self-checking bench for text_write_ctrl; clear-sweep scenarios
// follow TEXT_WRITE_CTRL_CLEAR_EN.
module tb_text_write_ctrl;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   we_cnt = 0;
    int   busy_cnt = 0;
    int   n42 = 0;

    text_write_ctrl_if bus ();

    text_write_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count RAM writes and busy cycles mid-cycle.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            we_cnt <= we_cnt + 1;
            if (bus.wr_data === 8'h42) n42 <= n42 + 1;
        end
        if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic put_char(input logic [7:0] b);
        send(b);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.ready); end
        checks++; if ({bus.we, bus.busy, bus.overrun} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {bus.we, bus.busy, bus.overrun}); end
        checks++; if ({bus.cur_row, bus.cur_col} !== 7'd0) begin errors++; $display("FAIL rst_cursor got=%0d,%0d exp=0,0", bus.cur_row, bus.cur_col); end
        checks++; if ({bus.wr_row, bus.wr_col, bus.wr_data} !== 15'd0) begin errors++; $display("FAIL rst_wr got=%0d,%0d,%h exp=0,0,00", bus.wr_row, bus.wr_col, bus.wr_data); end
    endtask

    task automatic test_put_a();
        int base;
        base = we_cnt;
        send(8'h41);
        checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL a_we got=%b exp=1", bus.we); end
        checks++; if ({bus.wr_row, bus.wr_col, bus.wr_data} !== {2'd0, 5'd0, 8'h41}) begin errors++; $display("FAIL a_wr got=%0d,%0d,%h exp=0,0,41", bus.wr_row, bus.wr_col, bus.wr_data); end
        checks++; if ({bus.cur_row, bus.cur_col} !== {2'd0, 5'd1}) begin errors++; $display("FAIL a_cursor got=%0d,%0d exp=0,1", bus.cur_row, bus.cur_col); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL a_ready_low got=%b exp=0", bus.ready); end
        step();
        checks++; if ({bus.ready, bus.we} !== 2'b10) begin errors++; $display("FAIL a_after got=ready%b/we%b exp=ready1/we0", bus.ready, bus.we); end
        checks++; if (we_cnt - base !== 1) begin errors++; $display("FAIL a_wcount got=%0d exp=1", we_cnt - base); end
    endtask

    task automatic test_drop();
        logic [7:0] drops [4];
        drops = '{8'hC1, 8'h1B, 8'h09, 8'h80};
        for (int i = 0; i < 4; i++) begin
            send(drops[i]);
            checks++;
            if ({bus.ready, bus.we, bus.cur_row, bus.cur_col} !== {1'b1, 1'b0, 2'd0, 5'd1}) begin
                errors++;
                $display("FAIL drop_%h got=ready%b we%b cur%0d,%0d exp=ready1 we0 cur0,1", drops[i], bus.ready, bus.we, bus.cur_row, bus.cur_col);
            end
        end
    endtask

    task automatic test_cr_lf_bs();
        int base;
        for (int i = 0; i < 36; i++) put_char(8'h61 + 8'(i % 26));
        checks++; if ({bus.cur_row, bus.cur_col} !== {2'd1, 5'd5}) begin errors++; $display("FAIL fill36_cursor got=%0d,%0d exp=1,5", bus.cur_row, bus.cur_col); end
        base = we_cnt;
        send(8'h0D);
        checks++; if ({bus.cur_row, bus.cur_col, bus.ready} !== {2'd1, 5'd0, 1'b1}) begin errors++; $display("FAIL cr got=%0d,%0d ready%b exp=1,0 ready1", bus.cur_row, bus.cur_col, bus.ready); end
        send(8'h0A);
        checks++; if ({bus.cur_row, bus.cur_col, bus.ready} !== {2'd2, 5'd0, 1'b1}) begin errors++; $display("FAIL lf got=%0d,%0d ready%b exp=2,0 ready1", bus.cur_row, bus.cur_col, bus.ready); end
        step();
        checks++; if (we_cnt - base !== 0) begin errors++; $display("FAIL crlf_nowrite got=%0d exp=0", we_cnt - base); end
        send(8'h08);
        checks++; if ({bus.we, bus.wr_row, bus.wr_col, bus.wr_data} !== {1'b1, 2'd1, 5'd31, 8'h20}) begin errors++; $display("FAIL bs_wr got=we%b %0d,%0d,%h exp=we1 1,31,20", bus.we, bus.wr_row, bus.wr_col, bus.wr_data); end
        checks++; if ({bus.cur_row, bus.cur_col} !== {2'd1, 5'd31}) begin errors++; $display("FAIL bs_cursor got=%0d,%0d exp=1,31", bus.cur_row, bus.cur_col); end
        step();
        send(8'h0D); send(8'h0A); send(8'h0A); send(8'h0A);
        checks++; if ({bus.cur_row, bus.cur_col} !== {2'd0, 5'd0}) begin errors++; $display("FAIL lf_wrap got=%0d,%0d exp=0,0", bus.cur_row, bus.cur_col); end
        base = we_cnt;
        send(8'h08);
        checks++; if ({bus.we, bus.ready, bus.cur_row, bus.cur_col} !== {1'b0, 1'b1, 2'd0, 5'd0}) begin errors++; $display("FAIL bs_origin got=we%b ready%b %0d,%0d exp=we0 ready1 0,0", bus.we, bus.ready, bus.cur_row, bus.cur_col); end
        step();
        checks++; if (we_cnt - base !== 0) begin errors++; $display("FAIL bs_origin_nowrite got=%0d exp=0", we_cnt - base); end
        put_char(8'h78);
        send(8'h7F);
        checks++; if ({bus.we, bus.wr_row, bus.wr_col, bus.wr_data, bus.cur_row, bus.cur_col} !== {1'b1, 2'd0, 5'd0, 8'h20, 2'd0, 5'd0}) begin errors++; $display("FAIL del got=we%b %0d,%0d,%h cur%0d,%0d exp=we1 0,0,20 cur0,0", bus.we, bus.wr_row, bus.wr_col, bus.wr_data, bus.cur_row, bus.cur_col); end
        step();
    endtask

    task automatic test_wrap();
        int base;
        int bad;
        send(8'h0A); send(8'h0A); send(8'h0A);
        checks++; if ({bus.cur_row, bus.cur_col} !== {2'd3, 5'd0}) begin errors++; $display("FAIL wrap_start got=%0d,%0d exp=3,0", bus.cur_row, bus.cur_col); end
        base = we_cnt;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            send(8'h30 + 8'(i % 10));
            if ({bus.we, bus.wr_row, bus.wr_col} !== {1'b1, 2'd3, 5'(i)}) bad++;
            if (i == 31) begin
                checks++; if ({bus.wr_data, bus.cur_row, bus.cur_col} !== {8'h31, 2'd0, 5'd0}) begin errors++; $display("FAIL wrap_last got=%h cur%0d,%0d exp=31 cur0,0", bus.wr_data, bus.cur_row, bus.cur_col); end
            end
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_addr got=%0d bad writes exp=0", bad); end
        checks++; if (we_cnt - base !== 32) begin errors++; $display("FAIL wrap_wcount got=%0d exp=32", we_cnt - base); end
    endtask

    task automatic test_overrun();
        int base;
        base = we_cnt;
        send(8'h43);
        send(8'h42);
        checks++; if ({bus.overrun, bus.we} !== 2'b10) begin errors++; $display("FAIL ovr_pulse got=ovr%b we%b exp=ovr1 we0", bus.overrun, bus.we); end
        step();
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_single got=%b exp=0", bus.overrun); end
        checks++; if ({bus.cur_row, bus.cur_col} !== {2'd0, 5'd1}) begin errors++; $display("FAIL ovr_cursor got=%0d,%0d exp=0,1", bus.cur_row, bus.cur_col); end
        checks++; if (n42 !== 0 || we_cnt - base !== 1) begin errors++; $display("FAIL ovr_dropped got=n42 %0d writes %0d exp=0,1", n42, we_cnt - base); end
    endtask

`ifdef TEXT_WRITE_CTRL_CLEAR_EN
    task automatic test_clear();
        int wbase;
        int bbase;
        int bad;
        for (int i = 0; i < 128; i++) put_char(8'h41 + 8'(i % 26));
        checks++; if ({bus.cur_row, bus.cur_col} !== {2'd0, 5'd1}) begin errors++; $display("FAIL fill_cursor got=%0d,%0d exp=0,1", bus.cur_row, bus.cur_col); end
        wbase = we_cnt;
        bbase = busy_cnt;
        send(8'h0C);
        checks++; if ({bus.busy, bus.ready, bus.we, bus.wr_row, bus.wr_col, bus.wr_data} !== {3'b101, 2'd0, 5'd0, 8'h20}) begin errors++; $display("FAIL clr_first got=busy%b ready%b we%b %0d,%0d,%h exp=busy1 ready0 we1 0,0,20", bus.busy, bus.ready, bus.we, bus.wr_row, bus.wr_col, bus.wr_data); end
        bad = 0;
        for (int k = 1; k < 128; k++) begin
            step();
            if ({bus.we, bus.busy, bus.wr_row, bus.wr_col, bus.wr_data} !== {2'b11, 2'(k / 32), 5'(k % 32), 8'h20}) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL clr_sweep got=%0d bad cycles exp=0", bad); end
        step();
        checks++; if ({bus.busy, bus.we, bus.ready, bus.cur_row, bus.cur_col} !== {3'b001, 2'd0, 5'd0}) begin errors++; $display("FAIL clr_end got=busy%b we%b ready%b cur%0d,%0d exp=busy0 we0 ready1 cur0,0", bus.busy, bus.we, bus.ready, bus.cur_row, bus.cur_col); end
        checks++; if (we_cnt - wbase !== 128 || busy_cnt - bbase !== 128) begin errors++; $display("FAIL clr_counts got=we%0d busy%0d exp=128,128", we_cnt - wbase, busy_cnt - bbase); end
    endtask

    task automatic test_reset_in_clear();
        int base;
        send(8'h0C);
        for (int i = 0; i < 39; i++) step();
        checks++; if ({bus.busy, bus.wr_row, bus.wr_col} !== {1'b1, 2'd1, 5'd7}) begin errors++; $display("FAIL clr40_pos got=busy%b %0d,%0d exp=busy1 1,7", bus.busy, bus.wr_row, bus.wr_col); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({bus.busy, bus.we, bus.cur_row, bus.cur_col} !== {2'b00, 2'd0, 5'd0}) begin errors++; $display("FAIL clr_abort got=busy%b we%b cur%0d,%0d exp=busy0 we0 cur0,0", bus.busy, bus.we, bus.cur_row, bus.cur_col); end
        base = we_cnt;
        step();
        checks++; if ({bus.we, bus.ready} !== 2'b01 || we_cnt - base !== 0) begin errors++; $display("FAIL clr_abort_idle got=we%b ready%b writes%0d exp=we0 ready1 writes0", bus.we, bus.ready, we_cnt - base); end
        send(8'h5A);
        checks++; if ({bus.we, bus.wr_row, bus.wr_col, bus.wr_data} !== {1'b1, 2'd0, 5'd0, 8'h5A}) begin errors++; $display("FAIL clr_abort_next got=we%b %0d,%0d,%h exp=we1 0,0,5a", bus.we, bus.wr_row, bus.wr_col, bus.wr_data); end
        step();
    endtask
`else
    task automatic test_clear();
        int base;
        base = we_cnt;
        send(8'h0C);
        checks++; if ({bus.we, bus.busy, bus.ready, bus.cur_row, bus.cur_col} !== {3'b001, 2'd0, 5'd1}) begin errors++; $display("FAIL ff_ignored got=we%b busy%b ready%b cur%0d,%0d exp=we0 busy0 ready1 cur0,1", bus.we, bus.busy, bus.ready, bus.cur_row, bus.cur_col); end
        step();
        checks++; if (bus.busy !== 1'b0 || we_cnt - base !== 0) begin errors++; $display("FAIL ff_nowrite got=busy%b writes%0d exp=busy0 writes0", bus.busy, we_cnt - base); end
    endtask

    task automatic test_reset_in_clear();
    endtask
`endif

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset        = 1'b1;
        test_reset();
        test_put_a();
        test_drop();
        test_cr_lf_bs();
        test_wrap();
        test_overrun();
        test_clear();
        test_reset_in_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
